// File: rtl/vga_timing_gen_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
package vga_timing_gen_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;
  localparam int unsigned DefClkDiv  = 4;

  // True for lo <= v < lo+len.
  function automatic logic in_window(int unsigned v, int unsigned lo, int unsigned len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Pixel-clock-enable divider: tick is high on the last clk of every CLK_DIV-clk pixel period.
module vga_timing_gen_pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;

  assign tick = run && (div_q == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else if (!run || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with run/stop control that stops on a frame boundary.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = DefClkDiv,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          pixel_tick,
  output logic          frame_start,
  output logic          running
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;

  state_t        state_q;
  logic          en_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          new_pos_q;
  logic          run;
  logic          tick;
  logic          x_last;
  logic          y_last;

  assign run    = (state_q != StIdle);
  assign x_last = (x_q == XW'(H_TOTAL - 1));
  assign y_last = (y_q == YW'(V_TOTAL - 1));

  vga_timing_gen_pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  // en is registered once so that a request seen at edge N shows on the outputs after edge N+2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      new_pos_q <= 1'b1;
    end else begin
      en_q <= en;
      // Divider sits at 0 after idle or after a tick: first clk of a new position.
      new_pos_q <= !run || tick;
      unique case (state_q)
        StIdle:  if (en_q) state_q <= StRun;
        StRun:   if (!en_q) state_q <= StDrain;
        StDrain: begin
          if (en_q) begin
            state_q <= StRun;
          end else if (tick && x_last && y_last) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (!run) begin
        x_q <= '0;
        y_q <= '0;
      end else if (tick) begin
        if (x_last) begin
          x_q <= '0;
          y_q <= y_last ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= 1'b0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      pixel_x     <= x_q;
      pixel_y     <= y_q;
      hsync       <= (run && in_window(32'(x_q), HS_START, H_SYNC)) ? HS_POL : ~HS_POL;
      vsync       <= (run && in_window(32'(y_q), VS_START, V_SYNC)) ? VS_POL : ~VS_POL;
      video_on    <= run && (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
      pixel_tick  <= run && new_pos_q;
      frame_start <= run && new_pos_q && (x_q == '0) && (y_q == '0);
      running     <= run;
    end
  end

endmodule
